// File: rtl/riscy_pkg.sv
// Shared constants for the riscy core: RV32I major opcodes, RAM address width,
// the canonical NOP and the fetch-stage state enum.
package riscy_pkg;

  localparam int ADDR_W = 14;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD    = 7'b000_0011;
  localparam logic [6:0] OP_MISCMEM = 7'b000_1111;
  localparam logic [6:0] OP_OPIMM   = 7'b001_0011;
  localparam logic [6:0] OP_AUIPC   = 7'b001_0111;
  localparam logic [6:0] OP_STORE   = 7'b010_0011;
  localparam logic [6:0] OP_OP      = 7'b011_0011;
  localparam logic [6:0] OP_LUI     = 7'b011_0111;
  localparam logic [6:0] OP_BRANCH  = 7'b110_0011;
  localparam logic [6:0] OP_JALR    = 7'b110_0111;
  localparam logic [6:0] OP_JAL     = 7'b110_1111;
  localparam logic [6:0] OP_SYSTEM  = 7'b111_0011;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {inst, pc, fault} entries.
// Flush empties it and may load one entry in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, wr_addr;
  logic [PW:0]   count_reg, count_next;

  assign wr_addr    = flush ? '0 : wr_ptr_reg;
  assign count_next = count_reg + (PW+1)'(push) - (PW+1)'(pop);
  assign head       = mem[rd_ptr_reg];
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_addr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      // Flush drops everything; a same-cycle push becomes the sole entry.
      rd_ptr_reg <= '0;
      wr_ptr_reg <= push ? PW'(1) : '0;
      count_reg  <= push ? (PW+1)'(1) : '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-based issue to the RAM port, redirect
// handling and a small output buffer. Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_W     = riscy_pkg::ADDR_W,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_out,
  input  logic              redirect_vld,
  input  logic [31:0]       redirect_pc,
  output logic              inst_vld,
  input  logic              inst_rdy,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_fault
);
  import riscy_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 65;

  fetch_state_e  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next, req_pc_reg, req_pc_next, target;
  logic          inflight_reg, inflight_next;
  logic          misalign, issue, push, pop;
  logic [CW:0]   occupancy;
  logic [CW-1:0] count;
  logic [EW-1:0] push_data, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign misalign   = redirect_vld & (redirect_pc[1:0] != 2'b00);
  assign inst_fault = inst_vld & head[0];
`else
  logic unused_bits;
  assign target      = {redirect_pc[31:2], 2'b00};
  assign misalign    = 1'b0;
  assign inst_fault  = 1'b0;
  assign unused_bits = ^{redirect_pc[1:0], head[0]};
`endif

  assign inst_vld = (count != '0);
  assign inst     = inst_vld ? head[64:33] : 32'h0;
  assign inst_pc  = inst_vld ? head[32:1]  : 32'h0;

  always_comb begin
    pop         = inst_vld & inst_rdy;
    occupancy   = {1'b0, count} + (CW+1)'(inflight_reg);
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    issue       = 1'b0;
    // The word returning this cycle is dropped if a redirect squashes it.
    push        = inflight_reg & ~redirect_vld;
    push_data   = {i_out, req_pc_reg, 1'b0};
    i_addr      = pc_reg[ADDR_W-1:0];
    if (redirect_vld) begin
      if (misalign) begin
        state_next = FAULT;
        push       = 1'b1;
        push_data  = {NOP_INST, redirect_pc, 1'b1};
      end else begin
        state_next  = RUN;
        issue       = 1'b1;
        i_addr      = target[ADDR_W-1:0];
        pc_next     = target + 32'd4;
        req_pc_next = target;
      end
    end else if (state_reg == RUN &&
                 (occupancy - (CW+1)'(pop)) < (CW+1)'(FIFO_DEPTH)) begin
      issue       = 1'b1;
      pc_next     = pc_reg + 32'd4;
      req_pc_next = pc_reg;
    end
    inflight_next = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      inflight_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_vld),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/redirect traffic checked against an in-order PC-stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] i_addr;
  logic [31:0] i_out = 32'h0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_vld;
  logic        inst_rdy = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;

  logic [31:0] mem [4096];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_xfer  = 0;
  int          age;
  logic [31:0] exp_pc, fault_pc, prev_inst, prev_pc;
  bit          hold_prev, fault_mode, fault_done;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_addr       (i_addr),
    .i_out        (i_out),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .inst_vld     (inst_vld),
    .inst_rdy     (inst_rdy),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_fault   (inst_fault)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous-read instruction RAM.
  always @(posedge clk) i_out <= mem[i_addr[13:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_rdy = 1'b0;
    redirect_vld = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_vld", inst_vld, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_fault", inst_fault, 0);
    check("rst_iaddr", i_addr, 0);
    rst = 1'b0;
    age = 0;
    exp_pc = 32'h0;
    hold_prev = 0;
    fault_mode = 0;
    fault_done = 0;
  endtask

  // One clock: observe registered outputs, apply inputs, update the model.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    if (age < 1000) age++;
    if (fault_mode) begin
      check("fault_vld", inst_vld, fault_done ? 0 : 1);
    end else if (age == 1) begin
      check("flush_vld", inst_vld, 0);
    end else if (age >= 2) begin
      check("stream_vld", inst_vld, 1);
    end
    if (hold_prev) begin
      check("hold_vld", inst_vld, 1);
      check("hold_inst", inst, prev_inst);
      check("hold_pc", inst_pc, prev_pc);
    end
    inst_rdy = rdy;
    redirect_vld = rv;
    redirect_pc = rpc;
    if (inst_vld && rdy) begin
      n_xfer++;
      $display("[TB] xfer pc=%08h inst=%08h fault=%0d", inst_pc, inst, inst_fault);
      if (fault_mode) begin
        check("nop_inst", inst, NOP);
        check("nop_pc", inst_pc, fault_pc);
        check("nop_fault", inst_fault, 1);
        fault_done = 1;
      end else begin
        check("xfer_pc", inst_pc, exp_pc);
        check("xfer_inst", inst, mem[exp_pc[13:2]]);
        check("xfer_fault", inst_fault, 0);
        exp_pc = exp_pc + 32'd4;
      end
    end
    hold_prev = inst_vld && !rdy && !rv;
    prev_inst = inst;
    prev_pc = inst_pc;
    if (rv) begin
      age = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) begin
        fault_mode = 1;
        fault_done = 0;
        fault_pc = rpc;
      end else begin
        fault_mode = 0;
        exp_pc = rpc;
      end
`else
      exp_pc = {rpc[31:2], 2'b00};
`endif
    end
  endtask

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    do_reset();
    // Reset stream, then a 5-cycle stall.
    repeat (8) step(1'b1, 1'b0, 32'h0);
    repeat (5) step(1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    // Redirect with a word in flight and one buffered.
    step(1'b1, 1'b1, 32'h100);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Back-to-back redirects: the later one wins.
    step(1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 32'h80);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // Misaligned target, then an aligned recovery.
    step(1'b1, 1'b1, 32'h102);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    // RAM address wrap at the top of the 16KB window.
    step(1'b1, 1'b1, 32'h3FFC);
    #1 check("iaddr_wrap_a", i_addr, 32'h3FFC);
    step(1'b1, 1'b0, 32'h0);
    #1 check("iaddr_wrap_b", i_addr, 32'h0);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 2))
        0:       rpc = $urandom;
        1:       rpc = 32'h3FF0 + 32'($urandom_range(0, 7)) * 32'd2;
        default: rpc = $urandom & 32'h3FFF;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
    end

    // Asynchronous reset in the middle of a live stream.
    step(1'b1, 1'b1, 32'h500);
    repeat (4) step(1'b1, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("async_vld", inst_vld, 0);
    check("async_iaddr", i_addr, 0);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 32'h0);

    check("xfer_seen", (n_xfer > 200) ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
